ps2_rx_fifo: RTL

Parametrised PS/2 keyboard receiver that runs on the system clock. It synchronises the raw PS/2 clock and data pins, deframes 11-bit frames with start, parity and stop checking, and folds E0/F0 prefixes into flags on each scancode. Decoded key events are buffered in a first-word-fall-through FIFO. It sits between the keyboard pins and game-control logic, which drains events at its own pace.

---
 rtl/ps2_rx_fifo.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin synchronisers, 11-bit deframer, E0/F0 prefix folding, FWFT event FIFO.
// Build option: define PS2_PARITY_CHECK_EN to enforce odd parity; otherwise the parity bit is skipped.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [9:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   prev_q;
    logic                   clk_s;
    logic                   dat_s;
    logic                   edge_det;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            prev_q     <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            prev_q     <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign dat_s    = dat_sync_q[SYNC_STAGES-1];
    assign edge_det = prev_q & ~clk_s;

    // ------------------------------------------------------------------
    // Deframer FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_d;
    logic          push_req;
    logic [9:0]    push_val;
    logic          frame_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic          par_q, par_d;
`endif

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = dat_s & (^{sr_q, par_q});
`else
    assign frame_ok = dat_s;
`endif

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        tmo_d    = tmo_q + TW'(1);
        err_d    = 1'b0;
        push_req = 1'b0;
        push_val = '0;
`ifdef PS2_PARITY_CHECK_EN
        par_d    = par_q;
`endif
        if (state_q == S_IDLE || edge_det) begin
            tmo_d = '0;
        end

        if (edge_det) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_s) begin
                        bit_d   = '0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    sr_d = {dat_s, sr_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d = dat_s;
`endif
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!frame_ok) begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end else if (sr_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (sr_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        push_val = {ext_q, brk_q, sr_q};
                        ext_d    = 1'b0;
                        brk_d    = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmo_q == TMO_MAX) begin
            // A stalled partial frame is abandoned; prefixes collected so far are stale.
            state_d = S_IDLE;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            sr_q    <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            tmo_q   <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            tmo_q   <= tmo_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q   <= par_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through event FIFO
    // ------------------------------------------------------------------
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          ferr_q;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign full  = (count_q == FULL_CNT);
    assign pop   = rd_en & (count_q != '0);
    // When full, a same-cycle pop frees the slot the write lands in.
    assign wr_en = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wptr_q] <= push_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            ovf_q  <= push_req & full & ~pop;
            ferr_q <= err_d;
        end
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rptr_q] : '0;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign frame_err  = ferr_q;

endmodule
